// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel stream multiplexer.
package mux_pkg;

   // Channel selection policy.
   typedef enum logic [0:0] {
      MODE_FIXED = 1'b0, // granted channel taken from the sel input
      MODE_RR    = 1'b1  // granted channel chosen round-robin among valid inputs
   } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last
// transferred channel. The pointer moves only when the caller reports a transfer.
module rr_arbiter #(
   parameter int unsigned CHANNELS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] req,
   input  logic                advance,
   output logic [CHANNELS-1:0] grant
);

   localparam int unsigned IdxW = $clog2(CHANNELS);

   logic [IdxW-1:0] last_q, last_d;
   logic [IdxW-1:0] pick;
   logic [IdxW-1:0] idx_w;
   logic            found;
   int unsigned     idx;

   // Search upward from last+1 with wrap-around; first requester wins.
   always_comb begin
      grant = '0;
      pick  = last_q;
      found = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
         idx   = (32'(last_q) + k) % CHANNELS;
         idx_w = idx[IdxW-1:0];
         if (!found && req[idx_w]) begin
            found        = 1'b1;
            grant[idx_w] = 1'b1;
            pick         = idx_w;
         end
      end
   end

   // A grant without a transfer must not move the pointer.
   always_comb begin
      last_d = advance ? pick : last_q;
   end

   // Pointer resets to the top channel so channel 0 is served first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= IdxW'(CHANNELS - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mux_stream_n.sv
// N-to-1 valid/ready stream multiplexer with a single registered output stage,
// fixed (sel-driven) or round-robin channel selection, and a transfer counter.
module mux_stream_n
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter mode_e       MODE     = MODE_FIXED
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [CHANNELS*WIDTH-1:0]    in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   input  logic [$clog2(CHANNELS)-1:0]  sel,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(CHANNELS)-1:0]  out_chan,
   output logic [15:0]                  beat_count
);

   localparam int unsigned SelW = $clog2(CHANNELS);

   logic [CHANNELS-1:0] grant;
   logic                free;
   logic                in_xfer;
   logic                out_xfer;
   logic [WIDTH-1:0]    mux_data;
   logic [SelW-1:0]     mux_chan;

   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [SelW-1:0]     out_chan_q, out_chan_d;
   logic                out_valid_q, out_valid_d;
   logic [15:0]         beat_count_q, beat_count_d;

   // Output stage can take a beat when empty or being drained this cycle.
   // reset_n gates in_ready so nothing is offered while reset is held.
   assign free     = ~out_valid_q | out_ready;
   assign in_ready = grant & {CHANNELS{free & reset_n}};
   assign in_xfer  = |(in_valid & in_ready);
   assign out_xfer = out_valid_q & out_ready;

   if (MODE == MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^sel;

      rr_arbiter #(
         .CHANNELS (CHANNELS)
      ) u_arb (
         .clk     (clk),
         .reset_n (reset_n),
         .req     (in_valid),
         .advance (in_xfer),
         .grant   (grant)
      );
   end else begin : g_fixed
      // Decode sel; out-of-range values match no channel and give no grant.
      always_comb begin
         grant = '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            grant[i] = (32'(sel) == i);
         end
      end
   end

   // One-hot AND-OR select of the granted channel's data and index.
   always_comb begin
      mux_data = '0;
      mux_chan = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
         mux_chan = mux_chan | (SelW'(i) & {SelW{grant[i]}});
      end
   end

   // Load on input transfer (drain and refill in one cycle keeps valid high),
   // clear valid on a bare output transfer, count every output transfer.
   always_comb begin
      out_data_d   = out_data_q;
      out_chan_d   = out_chan_q;
      out_valid_d  = out_valid_q;
      beat_count_d = beat_count_q;
      if (in_xfer) begin
         out_data_d  = mux_data;
         out_chan_d  = mux_chan;
         out_valid_d = 1'b1;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end
      if (out_xfer) begin
         beat_count_d = beat_count_q + 16'd1;
      end
   end

   // Output register and counter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data_q   <= '0;
         out_chan_q   <= '0;
         out_valid_q  <= 1'b0;
         beat_count_q <= '0;
      end else begin
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
         out_valid_q  <= out_valid_d;
         beat_count_q <= beat_count_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_chan   = out_chan_q;
   assign out_valid  = out_valid_q;
   assign beat_count = beat_count_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// Bench for mux_stream_n: fixed C=4, round-robin C=4 and fixed C=6 instances
// checked against a scoreboard of expected beats.
module tb_mux_stream_n;
   import mux_pkg::*;

   typedef struct packed {
      logic [3:0]  chan;
      logic [15:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Fixed C=4 instance
   logic [63:0] f_in_data = '0;
   logic [3:0]  f_in_valid = '0, f_in_ready;
   logic [1:0]  f_sel = '0, f_out_chan;
   logic [15:0] f_out_data, f_beat;
   logic        f_out_valid, f_out_ready = 1'b0;
   // Round-robin C=4 instance
   logic [63:0] r_in_data = '0;
   logic [3:0]  r_in_valid = '0, r_in_ready;
   logic [1:0]  r_sel = '0, r_out_chan;
   logic [15:0] r_out_data, r_beat;
   logic        r_out_valid, r_out_ready = 1'b0;
   // Fixed C=6 instance (3-bit sel)
   logic [95:0] s_in_data = '0;
   logic [5:0]  s_in_valid = '0, s_in_ready;
   logic [2:0]  s_sel = '0, s_out_chan;
   logic [15:0] s_out_data, s_beat;
   logic        s_out_valid, s_out_ready = 1'b0;

   // Bench-side model state
   beat_t f_q[$];
   beat_t r_q[$];
   logic  f_ov = 1'b0, r_ov = 1'b0;
   int    f_cnt = 0, r_cnt = 0, r_last = 3;

   mux_stream_n #(.WIDTH(16), .CHANNELS(4), .MODE(MODE_FIXED)) u_fix (
      .clk(clk), .reset_n(reset_n), .in_data(f_in_data), .in_valid(f_in_valid),
      .in_ready(f_in_ready), .sel(f_sel), .out_data(f_out_data), .out_valid(f_out_valid),
      .out_ready(f_out_ready), .out_chan(f_out_chan), .beat_count(f_beat));

   mux_stream_n #(.WIDTH(16), .CHANNELS(4), .MODE(MODE_RR)) u_rr (
      .clk(clk), .reset_n(reset_n), .in_data(r_in_data), .in_valid(r_in_valid),
      .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data), .out_valid(r_out_valid),
      .out_ready(r_out_ready), .out_chan(r_out_chan), .beat_count(r_beat));

   mux_stream_n #(.WIDTH(16), .CHANNELS(6), .MODE(MODE_FIXED)) u_fix6 (
      .clk(clk), .reset_n(reset_n), .in_data(s_in_data), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .sel(s_sel), .out_data(s_out_data), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_chan(s_out_chan), .beat_count(s_beat));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input int last, input logic [3:0] v);
      for (int k = 1; k <= 4; k++) begin
         if (v[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic test_reset();
      #1 reset_n = 1'b0;
      f_in_valid = 4'hF; f_sel = 2'd0; f_out_ready = 1'b1;
      r_in_valid = 4'hF; r_out_ready = 1'b1;
      s_in_valid = 6'h3F; s_sel = 3'd0; s_out_ready = 1'b1;
      #3;
      n_vec++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", f_out_valid); end
      n_vec++; if (f_out_data !== 16'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", f_out_data); end
      n_vec++; if (f_out_chan !== 2'd0) begin n_fail++; $display("FAIL rst_chan got %0d want 0", f_out_chan); end
      n_vec++; if (f_beat !== 16'h0) begin n_fail++; $display("FAIL rst_beat got %h want 0", f_beat); end
      n_vec++; if (f_in_ready !== 4'h0) begin n_fail++; $display("FAIL rst_fix_ready got %b want 0000", f_in_ready); end
      n_vec++; if (r_in_ready !== 4'h0) begin n_fail++; $display("FAIL rst_rr_ready got %b want 0000", r_in_ready); end
      n_vec++; if (s_in_ready !== 6'h0) begin n_fail++; $display("FAIL rst_fix6_ready got %b want 0", s_in_ready); end
      repeat (2) @(posedge clk);
      #2;
      n_vec++; if (r_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rr_valid got %b want 0", r_out_valid); end
      f_in_valid = '0; r_in_valid = '0; s_in_valid = '0;
      reset_n = 1'b1;
      #1;
   endtask

   // Back-to-back fixed selection; first step is the 0xBEEF on ch2 case.
   task automatic test_fixed_basic();
      int          sel_tab[6] = '{2, 0, 1, 2, 3, 3};
      logic [3:0]  val_tab[6] = '{4'b0100, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0111};
      logic [3:0]  exp_rdy;
      beat_t       b;
      f_out_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 4; i++) f_in_data[i*16 +: 16] = {4'(t), 4'(i), 8'hA5};
         if (t == 0) f_in_data[47:32] = 16'hBEEF;
         f_sel = 2'(sel_tab[t]); f_in_valid = val_tab[t];
         #1;
         exp_rdy = (!f_ov || f_out_ready) ? 4'(1 << sel_tab[t]) : 4'b0;
         n_vec++;
         if (f_in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL fix_ready step %0d got %b want %b", t, f_in_ready, exp_rdy);
         end
         if (f_ov && f_out_ready) begin b = f_q.pop_front(); f_cnt++; end
         if ((exp_rdy & val_tab[t]) != 0) begin
            b.chan = 4'(sel_tab[t]); b.data = f_in_data[sel_tab[t]*16 +: 16];
            f_q.push_back(b);
            f_ov = 1'b1;
         end else if (f_out_ready) begin
            f_ov = 1'b0;
         end
         tick();
         n_vec++;
         if (f_out_valid !== f_ov) begin
            n_fail++; $display("FAIL fix_valid step %0d got %b want %b", t, f_out_valid, f_ov);
         end
         if (f_ov) begin
            n_vec++;
            if (f_out_data !== f_q[0].data || f_out_chan !== 2'(f_q[0].chan)) begin
               n_fail++; $display("FAIL fix_beat step %0d got ch%0d %h want ch%0d %h", t,
                                  f_out_chan, f_out_data, f_q[0].chan, f_q[0].data);
            end
         end
      end
      f_in_valid = '0;
      #1;
      if (f_ov) begin b = f_q.pop_front(); f_cnt++; f_ov = 1'b0; end
      tick();
      n_vec++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL fix_drain got %b want 0", f_out_valid); end
      n_vec++; if (f_beat !== 16'(f_cnt)) begin n_fail++; $display("FAIL fix_count got %0d want %0d", f_beat, f_cnt); end
   endtask

   task automatic test_backpressure();
      f_sel = 2'd1; f_in_data = '0; f_in_data[31:16] = 16'h1234;
      f_in_valid = 4'b0010; f_out_ready = 1'b0;
      #1;
      n_vec++; if (f_in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_load_ready got %b want 0010", f_in_ready); end
      tick();
      for (int c = 0; c < 3; c++) begin
         f_sel = 2'd3; f_in_data = {4{16'h5555}}; f_in_valid = 4'hF;
         #1;
         n_vec++; if (f_in_ready !== 4'h0) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b want 0000", c, f_in_ready); end
         tick();
         n_vec++;
         if (f_out_valid !== 1'b1 || f_out_data !== 16'h1234 || f_out_chan !== 2'd1) begin
            n_fail++; $display("FAIL bp_hold cyc %0d got v%b ch%0d %h want v1 ch1 1234", c,
                               f_out_valid, f_out_chan, f_out_data);
         end
      end
      f_in_valid = '0; f_out_ready = 1'b1;
      tick();
      f_cnt++;
      n_vec++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", f_out_valid); end
      n_vec++; if (f_beat !== 16'(f_cnt)) begin n_fail++; $display("FAIL bp_count got %0d want %0d", f_beat, f_cnt); end
   endtask

   task automatic test_fixed_oob();
      s_sel = 3'd7; s_in_valid = 6'h3F; s_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) s_in_data[i*16 +: 16] = 16'h5A50 | 16'(i);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++; if (s_in_ready !== 6'h0) begin n_fail++; $display("FAIL oob_ready got %b want 0", s_in_ready); end
         tick();
         n_vec++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL oob_valid got %b want 0", s_out_valid); end
      end
      s_sel = 3'd5;
      #1;
      n_vec++; if (s_in_ready !== 6'b100000) begin n_fail++; $display("FAIL top_ready got %b want 100000", s_in_ready); end
      tick();
      n_vec++;
      if (s_out_valid !== 1'b1 || s_out_data !== 16'h5A55 || s_out_chan !== 3'd5) begin
         n_fail++; $display("FAIL top_beat got v%b ch%0d %h want v1 ch5 5a55", s_out_valid, s_out_chan, s_out_data);
      end
      s_sel = 3'd6;
      #1;
      n_vec++; if (s_in_ready !== 6'h0) begin n_fail++; $display("FAIL oob6_ready got %b want 0", s_in_ready); end
      tick();
      n_vec++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL oob6_drain got %b want 0", s_out_valid); end
      s_in_valid = '0;
   endtask

   task automatic test_rr_stream(input logic [3:0] valid, input logic [15:0] rdy_pat,
                                 input int steps, input string name);
      logic [3:0] exp_rdy;
      int         g;
      beat_t      b;
      for (int t = 0; t < steps; t++) begin
         for (int i = 0; i < 4; i++) r_in_data[i*16 +: 16] = {8'(t), 8'(i)};
         r_in_valid = valid; r_out_ready = rdy_pat[t];
         #1;
         g = rr_pick(r_last, valid);
         exp_rdy = ((!r_ov || r_out_ready) && g >= 0) ? 4'(1 << g) : 4'b0;
         n_vec++;
         if (r_in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL %s_ready step %0d got %b want %b", name, t, r_in_ready, exp_rdy);
         end
         if (r_ov && r_out_ready) begin b = r_q.pop_front(); r_cnt++; end
         if (exp_rdy != 0) begin
            b.chan = 4'(g); b.data = r_in_data[g*16 +: 16];
            r_q.push_back(b);
            r_last = g;
            r_ov = 1'b1;
         end else if (r_out_ready) begin
            r_ov = 1'b0;
         end
         tick();
         n_vec++;
         if (r_out_valid !== r_ov) begin
            n_fail++; $display("FAIL %s_valid step %0d got %b want %b", name, t, r_out_valid, r_ov);
         end
         if (r_ov) begin
            n_vec++;
            if (r_out_chan !== 2'(r_q[0].chan) || r_out_data !== r_q[0].data) begin
               n_fail++; $display("FAIL %s_beat step %0d got ch%0d %h want ch%0d %h", name, t,
                                  r_out_chan, r_out_data, r_q[0].chan, r_q[0].data);
            end
         end
      end
      r_in_valid = '0; r_out_ready = 1'b1;
      #1;
      if (r_ov) begin b = r_q.pop_front(); r_cnt++; r_ov = 1'b0; end
      tick();
      n_vec++; if (r_out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain got %b want 0", name, r_out_valid); end
      n_vec++; if (r_beat !== 16'(r_cnt)) begin n_fail++; $display("FAIL %s_count got %0d want %0d", name, r_beat, r_cnt); end
   endtask

   task automatic test_reset_mid();
      f_sel = 2'd0; f_in_data[15:0] = 16'h0F0F; f_in_valid = 4'b0001; f_out_ready = 1'b0;
      r_in_valid = 4'hF; r_out_ready = 1'b0;
      tick();
      @(negedge clk);
      #2 reset_n = 1'b0;
      f_in_valid = '0;
      #1;
      n_vec++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_fix_valid got %b want 0", f_out_valid); end
      n_vec++; if (f_beat !== 16'h0) begin n_fail++; $display("FAIL mid_fix_beat got %h want 0", f_beat); end
      n_vec++; if (f_out_data !== 16'h0) begin n_fail++; $display("FAIL mid_fix_data got %h want 0", f_out_data); end
      n_vec++; if (r_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rr_valid got %b want 0", r_out_valid); end
      n_vec++; if (r_beat !== 16'h0) begin n_fail++; $display("FAIL mid_rr_beat got %h want 0", r_beat); end
      tick();
      n_vec++; if (r_in_ready !== 4'h0) begin n_fail++; $display("FAIL mid_rr_ready got %b want 0000", r_in_ready); end
      #2 reset_n = 1'b1;
      f_q.delete(); r_q.delete();
      f_ov = 1'b0; r_ov = 1'b0; f_cnt = 0; r_cnt = 0; r_last = 3;
      r_out_ready = 1'b1;
      #1;
      n_vec++; if (r_in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got %b want 0001", r_in_ready); end
      tick();
      n_vec++;
      if (r_out_valid !== 1'b1 || r_out_chan !== 2'd0) begin
         n_fail++; $display("FAIL mid_first_beat got v%b ch%0d want v1 ch0", r_out_valid, r_out_chan);
      end
      r_in_valid = '0;
      tick();
      n_vec++; if (r_beat !== 16'd1) begin n_fail++; $display("FAIL mid_rr_count got %0d want 1", r_beat); end
   endtask

   task automatic test_wrap();
      int   cnt = 0;
      logic ov = 1'b0;
      f_sel = 2'd0; f_in_data[15:0] = 16'h7777; f_in_valid = 4'b0001; f_out_ready = 1'b1;
      for (int i = 0; i < 70000 && cnt != 32'hFFFF; i++) begin
         if (ov) cnt = (cnt + 1) & 32'hFFFF;
         ov = 1'b1;
         @(posedge clk);
      end
      #1;
      n_vec++; if (f_beat !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %h want ffff", f_beat); end
      tick();
      n_vec++; if (f_beat !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", f_beat); end
      n_vec++; if (f_out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", f_out_valid); end
      f_in_valid = '0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fixed_basic();
      test_backpressure();
      test_fixed_oob();
      test_rr_stream(4'b1111, 16'hFFFF, 6, "rr_all");
      test_rr_stream(4'b1010, 16'b0000_0011_1100_0111, 10, "rr_skip");
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
